multicycle_control: RTL and testbench

Sequencing FSM for the multi-cycle MIPS datapath. It replaces the single-cycle decoder with one-state-per-step control, and drives one shared ALU, one shared memory port (with a ready handshake), the register file and the PC. It also handles interrupt entry (IRQ outside kernel mode) and illegal-instruction exception entry. It decodes the same ISA subset as the single-cycle core and uses the same ALUFun encoding.

---
 rtl/multicycle_control.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: one state per datapath step, shared ALU/memory, IRQ and exception entry.
// Optional `WATCHDOG_EN builds a memory-wait timeout that pulses BusErr and enters EXCPT.
module multicycle_control #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       ker,
  input  logic       IRQ,
  input  logic       MemReady,
  input  logic       BranchTaken,
  output logic       PCWrite,
  output logic [2:0] PCSrc,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [5:0] ALUFun,
  output logic       ExtOp,
  output logic       LuOp,
  output logic       BusErr,
  output logic [3:0] State
);
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC_R = 4'd6, S_ALUWB = 4'd7,
                         S_EXEC_I = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_JR = 4'd11,
                         S_INTR = 4'd12, S_EXCPT = 4'd13;

  localparam logic [5:0] ALU_ADD = 6'b000000, ALU_SUB = 6'b000001, ALU_AND = 6'b011000,
                         ALU_OR  = 6'b011110, ALU_XOR = 6'b010110, ALU_NOR = 6'b010001,
                         ALU_SLL = 6'b100000, ALU_SRL = 6'b100001, ALU_SRA = 6'b100011,
                         ALU_EQ  = 6'b110011, ALU_NE  = 6'b110001, ALU_LT  = 6'b110101,
                         ALU_LEZ = 6'b111101, ALU_GTZ = 6'b111011, ALU_LTZ = 6'b111111;

  logic [3:0] st, st_nxt, disp;
  logic       irq_take, tmo;
  logic       r_ok, r_shift;
  logic [5:0] r_fun, i_fun, b_fun;

  assign State    = st;
  assign irq_take = IRQ & ~ker;

  // Instruction decode shared by DECODE dispatch and the execute states
  always_comb begin
    r_ok    = 1'b1;
    r_shift = 1'b0;
    r_fun   = ALU_ADD;
    case (Funct)
      6'h20, 6'h21: r_fun = ALU_ADD;
      6'h22, 6'h23: r_fun = ALU_SUB;
      6'h24:        r_fun = ALU_AND;
      6'h25:        r_fun = ALU_OR;
      6'h26:        r_fun = ALU_XOR;
      6'h27:        r_fun = ALU_NOR;
      6'h2a, 6'h2b: r_fun = ALU_LT;
      6'h00: begin r_fun = ALU_SLL; r_shift = 1'b1; end
      6'h02: begin r_fun = ALU_SRL; r_shift = 1'b1; end
      6'h03: begin r_fun = ALU_SRA; r_shift = 1'b1; end
      default: r_ok = 1'b0;
    endcase

    case (OpCode)
      6'h0a, 6'h0b: i_fun = ALU_LT;
      6'h0c:        i_fun = ALU_AND;
      default:      i_fun = ALU_ADD;
    endcase

    case (OpCode)
      6'h04:   b_fun = ALU_EQ;
      6'h05:   b_fun = ALU_NE;
      6'h06:   b_fun = ALU_LEZ;
      6'h07:   b_fun = ALU_GTZ;
      default: b_fun = ALU_LTZ;
    endcase

    case (OpCode)
      6'h00: begin
        if (Funct == 6'h08 || Funct == 6'h09) disp = S_JR;
        else if (r_ok)                         disp = S_EXEC_R;
        else                                   disp = S_EXCPT;
      end
      6'h23, 6'h2b:                             disp = S_MEMADR;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: disp = S_EXEC_I;
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07:        disp = S_BRANCH;
      6'h02, 6'h03:                             disp = S_JUMP;
      default:                                  disp = S_EXCPT;
    endcase
  end

`ifdef WATCHDOG_EN
  // wcnt counts wait cycles already spent; the TIMEOUT-th consecutive wait cycle is the one that errors
  logic       waiting;
  logic [7:0] wcnt;
  assign waiting = ((st == S_FETCH) & ~irq_take) | (st == S_MEMRD) | (st == S_MEMWR);
  assign tmo     = waiting & ~MemReady & (wcnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset)                                      wcnt <= '0;
    else if (waiting & ~MemReady & (st_nxt == st))  wcnt <= wcnt + 8'd1;
    else                                            wcnt <= '0;
  end
`else
  assign tmo = 1'b0;
`endif

  assign BusErr = tmo & ~reset;

  always_ff @(posedge clk) begin
    if (reset) st <= S_FETCH;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = S_FETCH;
    case (st)
      S_FETCH: begin
        if (irq_take)      st_nxt = S_INTR;
        else if (MemReady) st_nxt = S_DECODE;
        else if (tmo)      st_nxt = S_EXCPT;
        else               st_nxt = S_FETCH;
      end
      S_DECODE: st_nxt = disp;
      S_MEMADR: st_nxt = (OpCode == 6'h23) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  st_nxt = MemReady ? S_MEMWB : (tmo ? S_EXCPT : S_MEMRD);
      S_MEMWR:  st_nxt = MemReady ? S_FETCH : (tmo ? S_EXCPT : S_MEMWR);
      S_EXEC_R, S_EXEC_I: st_nxt = S_ALUWB;
      default:  st_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite  = 1'b0;  PCSrc    = 3'd0;  IRWrite = 1'b0;  IorD  = 1'b0;
    MemRead  = 1'b0;  MemWrite = 1'b0;  RegWrite = 1'b0; RegDst = 2'd0;
    MemtoReg = 2'd0;  ALUSrcA  = 2'd0;  ALUSrcB = 2'd0;  ALUFun = ALU_ADD;
    ExtOp    = 1'b0;  LuOp     = 1'b0;
    case (st)
      S_FETCH: if (!irq_take) begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        if (MemReady) begin IRWrite = 1'b1; PCWrite = 1'b1; end
      end
      S_DECODE: begin ALUSrcB = 2'd3; ExtOp = 1'b1; end
      S_MEMADR: begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; ExtOp = 1'b1; end
      S_MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
      S_MEMWB:  begin RegWrite = 1'b1; RegDst = 2'd1; MemtoReg = 2'd1; end
      S_MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; end
      S_EXEC_R: begin ALUSrcA = r_shift ? 2'd2 : 2'd1; ALUFun = r_fun; end
      S_EXEC_I: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        ExtOp   = (OpCode != 6'h0c);
        LuOp    = (OpCode == 6'h0f);
        ALUFun  = i_fun;
      end
      S_ALUWB:  begin RegWrite = 1'b1; RegDst = (OpCode == 6'h00) ? 2'd0 : 2'd1; end
      S_BRANCH: begin
        ALUSrcA = 2'd1;
        ALUFun  = b_fun;
        if (BranchTaken) begin PCWrite = 1'b1; PCSrc = 3'd1; end
      end
      S_JUMP: begin
        PCWrite = 1'b1; PCSrc = 3'd2;
        if (OpCode == 6'h03) begin RegWrite = 1'b1; RegDst = 2'd2; MemtoReg = 2'd2; end
      end
      S_JR: begin
        PCWrite = 1'b1; PCSrc = 3'd3;
        if (Funct == 6'h09) begin RegWrite = 1'b1; MemtoReg = 2'd2; end
      end
      // INTR saves the un-incremented PC, EXCPT saves PC+4; the datapath supplies which
      S_INTR:  begin RegWrite = 1'b1; RegDst = 2'd3; MemtoReg = 2'd2; PCWrite = 1'b1; PCSrc = 3'd4; end
      S_EXCPT: begin RegWrite = 1'b1; RegDst = 2'd3; MemtoReg = 2'd2; PCWrite = 1'b1; PCSrc = 3'd5; end
      default: ;
    endcase
    if (reset) begin
      PCWrite = 1'b0; IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected step lists built from the ISA table.
module tb_multicycle_control;
  localparam int TO = 15;
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_J = 5, C_JAL = 6,
                 C_JR = 7, C_JALR = 8, C_ILL = 9;
  localparam logic [5:0] A_ADD = 6'b000000, A_SUB = 6'b000001, A_AND = 6'b011000,
                         A_OR = 6'b011110, A_XOR = 6'b010110, A_NOR = 6'b010001,
                         A_SLL = 6'b100000, A_SRL = 6'b100001, A_SRA = 6'b100011,
                         A_EQ = 6'b110011, A_NE = 6'b110001, A_LT = 6'b110101,
                         A_LEZ = 6'b111101, A_GTZ = 6'b111011, A_LTZ = 6'b111111;

  logic clk, reset, ker, IRQ, MemReady, BranchTaken;
  logic [5:0] OpCode, Funct;
  logic PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, ExtOp, LuOp, BusErr;
  logic [2:0] PCSrc;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB;
  logic [5:0] ALUFun;
  logic [3:0] State;

  multicycle_control #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .ker(ker), .IRQ(IRQ),
    .MemReady(MemReady), .BranchTaken(BranchTaken), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUFun(ALUFun), .ExtOp(ExtOp), .LuOp(LuOp), .BusErr(BusErr),
    .State(State));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op, funct;
    int         cls;
    logic [5:0] fun;
    logic [1:0] asa;
  } ins_t;

  // we = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite}
  typedef struct {
    logic [3:0] st;
    bit         rdy, irq, kr, bt;
    logic [4:0] we;
    logic [2:0] pcsrc;
    logic [1:0] regdst, m2r, asa, asb;
    logic [5:0] fun;
    bit         chkf, chkx, ext, lu;
  } step_t;

  int ncmp = 0, nerr = 0;
  step_t q[$];
  ins_t  tab[$];
  bit    c_irq, c_ker, c_bt;

  function automatic ins_t mkins(logic [5:0] op, logic [5:0] f, int cls, logic [5:0] fun, logic [1:0] asa);
    ins_t i;
    i.op = op; i.funct = f; i.cls = cls; i.fun = fun; i.asa = asa;
    return i;
  endfunction

  function automatic step_t mk(logic [3:0] st, bit rdy, logic [4:0] we);
    step_t s;
    s.st = st; s.rdy = rdy; s.irq = c_irq; s.kr = c_ker; s.bt = c_bt; s.we = we;
    s.pcsrc = 3'd0; s.regdst = 2'd0; s.m2r = 2'd0; s.asa = 2'd0; s.asb = 2'd0;
    s.fun = A_ADD; s.chkf = 1'b0; s.chkx = 1'b0; s.ext = 1'b0; s.lu = 1'b0;
    return s;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, straight from the ISA step rules
  task automatic build(input ins_t ins, input int fw, input int mw, input bit bt, input bit irq, input bit kr);
    step_t s;
    c_irq = irq; c_ker = kr; c_bt = bt;
    if (irq && !kr) begin
      q.push_back(mk(4'd0, 1'($urandom), 5'b00000));
      s = mk(4'd12, 1'($urandom), 5'b10001); s.pcsrc = 3'd4; s.regdst = 2'd3; s.m2r = 2'd2;
      q.push_back(s);
      return;
    end
    repeat (fw) q.push_back(mk(4'd0, 1'b0, 5'b00100));
    s = mk(4'd0, 1'b1, 5'b11100); s.chkf = 1; s.chkx = 1; s.asb = 2'd1; q.push_back(s);
    s = mk(4'd1, 1'($urandom), 5'b00000); s.chkx = 1; s.asb = 2'd3; s.ext = 1; q.push_back(s);
    case (ins.cls)
      C_R, C_I: begin
        s = mk((ins.cls == C_R) ? 4'd6 : 4'd8, 1'($urandom), 5'b00000);
        s.chkf = 1; s.fun = ins.fun; s.asa = ins.asa; s.chkx = 1;
        if (ins.cls == C_I) begin
          s.asb = 2'd2; s.ext = (ins.op != 6'h0c); s.lu = (ins.op == 6'h0f);
        end
        q.push_back(s);
        s = mk(4'd7, 1'($urandom), 5'b00001); s.regdst = (ins.cls == C_R) ? 2'd0 : 2'd1;
        q.push_back(s);
      end
      C_LD, C_ST: begin
        s = mk(4'd2, 1'($urandom), 5'b00000);
        s.chkf = 1; s.asa = 2'd1; s.chkx = 1; s.asb = 2'd2; s.ext = 1; q.push_back(s);
        repeat (mw) q.push_back(mk((ins.cls == C_LD) ? 4'd3 : 4'd5, 1'b0,
                                   (ins.cls == C_LD) ? 5'b00100 : 5'b00010));
        q.push_back(mk((ins.cls == C_LD) ? 4'd3 : 4'd5, 1'b1,
                       (ins.cls == C_LD) ? 5'b00100 : 5'b00010));
        if (ins.cls == C_LD) begin
          s = mk(4'd4, 1'($urandom), 5'b00001); s.regdst = 2'd1; s.m2r = 2'd1; q.push_back(s);
        end
      end
      C_BR: begin
        s = mk(4'd9, 1'($urandom), bt ? 5'b10000 : 5'b00000);
        s.pcsrc = 3'd1; s.chkf = 1; s.fun = ins.fun; s.asa = 2'd1; q.push_back(s);
      end
      C_J, C_JAL: begin
        s = mk(4'd10, 1'($urandom), (ins.cls == C_JAL) ? 5'b10001 : 5'b10000);
        s.pcsrc = 3'd2; s.regdst = 2'd2; s.m2r = 2'd2; q.push_back(s);
      end
      C_JR, C_JALR: begin
        s = mk(4'd11, 1'($urandom), (ins.cls == C_JALR) ? 5'b10001 : 5'b10000);
        s.pcsrc = 3'd3; s.regdst = 2'd0; s.m2r = 2'd2; q.push_back(s);
      end
      default: begin
        s = mk(4'd13, 1'($urandom), 5'b10001);
        s.pcsrc = 3'd5; s.regdst = 2'd3; s.m2r = 2'd2; q.push_back(s);
      end
    endcase
  endtask

  task automatic run_steps(input string tag);
    step_t s;
    int n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      MemReady = s.rdy; IRQ = s.irq; ker = s.kr; BranchTaken = s.bt;
      @(negedge clk);
      ncmp++;
      if (State !== s.st) begin
        nerr++; $display("FAIL %s step%0d state: got %0d want %0d", tag, n, State, s.st);
      end
      ncmp++;
      if ({PCWrite, IRWrite, MemRead, MemWrite, RegWrite} !== s.we) begin
        nerr++;
        $display("FAIL %s step%0d enables: got %b want %b", tag, n,
                 {PCWrite, IRWrite, MemRead, MemWrite, RegWrite}, s.we);
      end
      if (s.we[4]) begin
        ncmp++;
        if (PCSrc !== s.pcsrc) begin
          nerr++; $display("FAIL %s step%0d PCSrc: got %0d want %0d", tag, n, PCSrc, s.pcsrc);
        end
      end
      if (s.we[0]) begin
        ncmp++;
        if ({RegDst, MemtoReg} !== {s.regdst, s.m2r}) begin
          nerr++;
          $display("FAIL %s step%0d RegDst/MemtoReg: got %0d/%0d want %0d/%0d", tag, n,
                   RegDst, MemtoReg, s.regdst, s.m2r);
        end
      end
      if (s.chkf) begin
        ncmp++;
        if ({ALUFun, ALUSrcA} !== {s.fun, s.asa}) begin
          nerr++;
          $display("FAIL %s step%0d ALUFun/ALUSrcA: got %b/%0d want %b/%0d", tag, n,
                   ALUFun, ALUSrcA, s.fun, s.asa);
        end
      end
      if (s.chkx) begin
        ncmp++;
        if ({ALUSrcB, ExtOp, LuOp} !== {s.asb, s.ext, s.lu}) begin
          nerr++;
          $display("FAIL %s step%0d ALUSrcB/ExtOp/LuOp: got %0d/%b/%b want %0d/%b/%b", tag, n,
                   ALUSrcB, ExtOp, LuOp, s.asb, s.ext, s.lu);
        end
      end
      ncmp++;
      if (BusErr !== 1'b0) begin
        nerr++; $display("FAIL %s step%0d BusErr: got %b want 0", tag, n, BusErr);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_ins(input ins_t i, input int fw, input int mw, input bit bt,
                        input bit irq, input bit kr, input string tag);
    OpCode = i.op; Funct = i.funct;
    build(i, fw, mw, bt, irq, kr);
    run_steps(tag);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    @(negedge clk);
    ncmp++;
    if (State !== 4'd0 || {PCWrite, IRWrite, MemRead, MemWrite, RegWrite} !== 5'b0) begin
      nerr++; $display("FAIL reset_init: State=%0d enables=%b want 0/00000", State,
                       {PCWrite, IRWrite, MemRead, MemWrite, RegWrite});
    end
    @(posedge clk); #1;
    reset = 1'b0; OpCode = 6'h23; Funct = 6'h00; MemReady = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    MemReady = 1'b0;
    @(negedge clk);
    ncmp++;
    if (State !== 4'd3 || MemRead !== 1'b1) begin
      nerr++; $display("FAIL reset_memrd_reach: State=%0d MemRead=%b want 3/1", State, MemRead);
    end
    reset = 1'b1;
    #1;
    ncmp++;
    if (MemRead !== 1'b0 || RegWrite !== 1'b0) begin
      nerr++; $display("FAIL reset_gate1: MemRead=%b RegWrite=%b want 0/0", MemRead, RegWrite);
    end
    @(posedge clk); #1;
    @(negedge clk);
    ncmp++;
    if (State !== 4'd0 || MemRead !== 1'b0 || RegWrite !== 1'b0 || PCWrite !== 1'b0) begin
      nerr++; $display("FAIL reset_gate2: State=%0d MemRead=%b RegWrite=%b PCWrite=%b want 0/0/0/0",
                       State, MemRead, RegWrite, PCWrite);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_add();
    do_ins(mkins(6'h00, 6'h20, C_R, A_ADD, 2'd1), 0, 0, 1'b0, 1'b0, 1'b0, "add");
    do_ins(mkins(6'h00, 6'h00, C_R, A_SLL, 2'd2), 1, 0, 1'b0, 1'b0, 1'b0, "sll");
  endtask

  task automatic test_lw_wait();
    do_ins(mkins(6'h23, 6'h00, C_LD, A_ADD, 2'd1), 0, 3, 1'b0, 1'b0, 1'b0, "lw_wait");
    do_ins(mkins(6'h2b, 6'h00, C_ST, A_ADD, 2'd1), 2, 2, 1'b0, 1'b0, 1'b0, "sw_wait");
  endtask

  task automatic test_branch();
    do_ins(mkins(6'h04, 6'h00, C_BR, A_EQ, 2'd1), 0, 0, 1'b1, 1'b0, 1'b0, "beq_taken");
    do_ins(mkins(6'h04, 6'h00, C_BR, A_EQ, 2'd1), 0, 0, 1'b0, 1'b0, 1'b0, "beq_not");
    do_ins(mkins(6'h01, 6'h00, C_BR, A_LTZ, 2'd1), 0, 0, 1'b1, 1'b0, 1'b0, "bltz_taken");
  endtask

  task automatic test_irq();
    do_ins(mkins(6'h00, 6'h20, C_R, A_ADD, 2'd1), 0, 0, 1'b0, 1'b1, 1'b0, "irq_enter");
    do_ins(mkins(6'h00, 6'h20, C_R, A_ADD, 2'd1), 1, 0, 1'b0, 1'b1, 1'b1, "irq_masked");
  endtask

  task automatic test_illegal();
    do_ins(mkins(6'h3f, 6'h00, C_ILL, A_ADD, 2'd0), 0, 0, 1'b0, 1'b0, 1'b0, "illegal_3f");
    do_ins(mkins(6'h00, 6'h3f, C_ILL, A_ADD, 2'd0), 0, 0, 1'b0, 1'b0, 1'b0, "illegal_funct");
  endtask

  task automatic test_random();
    ins_t i;
    for (int k = 0; k < 300; k++) begin
      i = tab[$urandom_range(0, tab.size() - 1)];
      do_ins(i, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 5) == 0,
             1'($urandom), $sformatf("rand%0d_op%02h_f%02h", k, i.op, i.funct));
    end
  endtask

  task automatic test_watchdog();
    OpCode = 6'h00; Funct = 6'h20; IRQ = 1'b0; ker = 1'b0; MemReady = 1'b0;
`ifdef WATCHDOG_EN
    for (int w = 1; w <= TO; w++) begin
      @(negedge clk);
      ncmp++;
      if (State !== 4'd0 || BusErr !== (w == TO)) begin
        nerr++; $display("FAIL watchdog_wait%0d: State=%0d BusErr=%b want 0/%b", w, State, BusErr, w == TO);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    ncmp++;
    if (State !== 4'd13 || PCSrc !== 3'd5 || BusErr !== 1'b0) begin
      nerr++; $display("FAIL watchdog_excpt: State=%0d PCSrc=%0d BusErr=%b want 13/5/0", State, PCSrc, BusErr);
    end
    @(posedge clk); #1;
`else
    for (int w = 1; w <= TO + 5; w++) begin
      @(negedge clk);
      ncmp++;
      if (State !== 4'd0 || BusErr !== 1'b0 || MemRead !== 1'b1) begin
        nerr++; $display("FAIL nowatchdog_wait%0d: State=%0d BusErr=%b MemRead=%b want 0/0/1",
                         w, State, BusErr, MemRead);
      end
      @(posedge clk); #1;
    end
`endif
    @(negedge clk);
    ncmp++;
    if (State !== 4'd0) begin
      nerr++; $display("FAIL final_fetch: State=%0d want 0", State);
    end
  endtask

  initial begin
    reset = 1'b1; OpCode = 6'h00; Funct = 6'h20; ker = 1'b0; IRQ = 1'b0;
    MemReady = 1'b0; BranchTaken = 1'b0;
    tab.push_back(mkins(6'h00, 6'h20, C_R, A_ADD, 2'd1)); tab.push_back(mkins(6'h00, 6'h21, C_R, A_ADD, 2'd1));
    tab.push_back(mkins(6'h00, 6'h22, C_R, A_SUB, 2'd1)); tab.push_back(mkins(6'h00, 6'h23, C_R, A_SUB, 2'd1));
    tab.push_back(mkins(6'h00, 6'h24, C_R, A_AND, 2'd1)); tab.push_back(mkins(6'h00, 6'h25, C_R, A_OR, 2'd1));
    tab.push_back(mkins(6'h00, 6'h26, C_R, A_XOR, 2'd1)); tab.push_back(mkins(6'h00, 6'h27, C_R, A_NOR, 2'd1));
    tab.push_back(mkins(6'h00, 6'h00, C_R, A_SLL, 2'd2)); tab.push_back(mkins(6'h00, 6'h02, C_R, A_SRL, 2'd2));
    tab.push_back(mkins(6'h00, 6'h03, C_R, A_SRA, 2'd2)); tab.push_back(mkins(6'h00, 6'h2a, C_R, A_LT, 2'd1));
    tab.push_back(mkins(6'h00, 6'h2b, C_R, A_LT, 2'd1));  tab.push_back(mkins(6'h00, 6'h08, C_JR, A_ADD, 2'd0));
    tab.push_back(mkins(6'h00, 6'h09, C_JALR, A_ADD, 2'd0));
    tab.push_back(mkins(6'h23, 6'h11, C_LD, A_ADD, 2'd1)); tab.push_back(mkins(6'h2b, 6'h05, C_ST, A_ADD, 2'd1));
    tab.push_back(mkins(6'h08, 6'h00, C_I, A_ADD, 2'd1)); tab.push_back(mkins(6'h09, 6'h00, C_I, A_ADD, 2'd1));
    tab.push_back(mkins(6'h0a, 6'h00, C_I, A_LT, 2'd1));  tab.push_back(mkins(6'h0b, 6'h00, C_I, A_LT, 2'd1));
    tab.push_back(mkins(6'h0c, 6'h00, C_I, A_AND, 2'd1)); tab.push_back(mkins(6'h0f, 6'h00, C_I, A_ADD, 2'd1));
    tab.push_back(mkins(6'h04, 6'h00, C_BR, A_EQ, 2'd1)); tab.push_back(mkins(6'h05, 6'h00, C_BR, A_NE, 2'd1));
    tab.push_back(mkins(6'h06, 6'h00, C_BR, A_LEZ, 2'd1)); tab.push_back(mkins(6'h07, 6'h00, C_BR, A_GTZ, 2'd1));
    tab.push_back(mkins(6'h01, 6'h00, C_BR, A_LTZ, 2'd1)); tab.push_back(mkins(6'h02, 6'h00, C_J, A_ADD, 2'd0));
    tab.push_back(mkins(6'h03, 6'h00, C_JAL, A_ADD, 2'd0));
    tab.push_back(mkins(6'h3f, 6'h00, C_ILL, A_ADD, 2'd0)); tab.push_back(mkins(6'h0d, 6'h00, C_ILL, A_ADD, 2'd0));
    tab.push_back(mkins(6'h20, 6'h00, C_ILL, A_ADD, 2'd0)); tab.push_back(mkins(6'h00, 6'h01, C_ILL, A_ADD, 2'd0));
    tab.push_back(mkins(6'h00, 6'h3f, C_ILL, A_ADD, 2'd0));

    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_irq();
    test_illegal();
    test_random();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
